lcd_sync_fifo: RTL
==================

Name: lcd_sync_fifo

Overview:
Single-clock, parameterised synchronous FIFO that replaces the dual-clock FIFO IP wrapper on paths where both sides share one clock (LCD pixel staging, CPU-to-display command queue).
Adds the following over the previous generation:
- selectable first-word-fall-through (FWFT) or standard read mode
- synchronous flush
- sticky overflow/underflow error flags
- a single unified water level
Storage is an inferred simple dual-port RAM; control is fully synchronous.

Parameters:
DATA_WIDTH, 16, word width in bits (1..256)
DEPTH_WIDTH, 9, log2 of RAM depth; RAM holds 2^DEPTH_WIDTH words (4..16)
FWFT, 0, 0 = standard read (data one cycle after rd_en); 1 = first-word-fall-through
ALMOST_FULL_NUM, 508, almost_full asserted when level >= this value
ALMOST_EMPTY_NUM, 4, almost_empty asserted when level <= this value

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  synchronous active-low reset (single clock; reset is synchronous, active-low)
flush  input  1  synchronous clear of FIFO contents and error flags
wr_en  input  1  write request
wr_data  input  DATA_WIDTH  write word
wr_full  output  1  RAM full, write will be rejected
almost_full  output  1  level >= ALMOST_FULL_NUM
rd_en  input  1  read request (FWFT: acknowledge/pop of the presented word)
rd_data  output  DATA_WIDTH  read word
rd_empty  output  1  no readable word
almost_empty  output  1  level <= ALMOST_EMPTY_NUM
level  output  DEPTH_WIDTH+1  words accepted and not yet consumed
overflow  output  1  sticky: write attempted while wr_full
underflow  output  1  sticky: read attempted while rd_empty

Behaviour:
- Pointers are DEPTH_WIDTH+1 bits and use the MSB wrap bit. mem_cnt = wptr - rptr, modulo 2^(DEPTH_WIDTH+1).
- wr_full = (mem_cnt == 2^DEPTH_WIDTH).
- wr_acc = wr_en & !wr_full & !flush.
- rd_acc = rd_en & !rd_empty & !flush.
- Full/empty are evaluated on the pre-edge state:
  - write while full is rejected even if a read occurs in the same cycle;
  - read while empty is rejected even if a write occurs in the same cycle.
- Rejected write: RAM and pointers unchanged, overflow <= 1. Rejected read: state unchanged, underflow <= 1. Flags hold until rst_n low or flush.
- Standard mode (FWFT=0):
  - rd_empty = (mem_cnt == 0).
  - rd_data is registered: the word at rptr appears the cycle after rd_acc.
  - rd_data holds its value otherwise.
  - level = mem_cnt.
- FWFT mode:
  - One output register plus out_valid.
  - out_valid loads from RAM whenever (!out_valid | rd_acc) and mem_cnt != 0.
  - rd_empty = !out_valid; rd_data = output register.
  - level = mem_cnt + out_valid, so maximum level = 2^DEPTH_WIDTH + 1.
  - wr_full still refers to the RAM only.
  - A write at edge 0 into a fully empty FIFO gives rd_empty = 0 after edge 1, with rd_data equal to that word (one-cycle fall-through after the write is visible).
- Flush:
  - Next edge: wptr = rptr = 0, out_valid = 0, level = 0, overflow = underflow = 0.
  - rd_data is retained; RAM contents are not cleared.
  - Flush wins over a simultaneous wr_en or rd_en; the dropped access does not set an error flag.
- Reset (rst_n == 0 at edge): same as flush, plus rd_data <= 0.
- Reset asserted mid-transfer discards all data.
- Outputs after reset: wr_full 0, rd_empty 1, almost_empty 1, almost_full 0 (1 only if ALMOST_FULL_NUM == 0), level 0, overflow 0, underflow 0, rd_data 0.
- almost_full and almost_empty are combinational compares of the registered level and change in the same cycle as level.
- Simultaneous wr_acc and rd_acc: level unchanged, both pointers advance.
- Wrap-around: pointers roll over at 2^(DEPTH_WIDTH+1) with no bubble.
- Throughput: one write and one read per cycle sustained, in both modes.

Decomposition:
- Shared package lcd_fifo_pkg:
  - localparam function for depth (1 << DEPTH_WIDTH);
  - pointer-width constant;
  - mode constants FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1.
- One sub-module, lcd_sync_fifo_ram: inferred simple dual-port RAM with write port (we, waddr, wdata) and registered read port (re, raddr, rdata). No reset on the array.
- Pointer, flag, level and FWFT logic all sit in lcd_sync_fifo.

Test Plan:
1. DATA_WIDTH=16, DEPTH_WIDTH=4, FWFT=0: write 0x0001..0x0010 on 16 consecutive cycles -> wr_full=1 after the 16th edge, level=16; 17th write 0xDEAD -> overflow=1, level stays 16; read 16 -> 0x0001..0x0010 in order, each one cycle after rd_en, then rd_empty=1.
2. FWFT=1, empty: single write 0x00A5 -> rd_empty=0 and rd_data=0x00A5 one cycle after the write edge; rd_en one cycle -> rd_empty=1, level=0; fill to 16 RAM words plus the output word -> level=17, wr_full=1.
3. Both modes, 40 cycles of simultaneous wr_en/rd_en at level 3 with an incrementing pattern -> level constant at 3, data in order across two pointer wraps, no flags set.
4. rd_en while empty, same cycle as wr_en of 0x1234 -> underflow=1, write accepted, level=1; then flush -> level=0, rd_empty=1, underflow=0, overflow=0.
5. ALMOST_FULL_NUM=14, ALMOST_EMPTY_NUM=2: fill 0->16 -> almost_empty drops on level 3, almost_full rises on level 14; drain -> almost_full drops at 13, almost_empty rises at 2.
6. Level 9 with wr_en and rd_en active: drive rst_n=0 for one edge -> all outputs at reset values next cycle, rd_data=0, previously stored words never appear on rd_data.

Source files
------------

// File: rtl/lcd_fifo_pkg.sv
// Shared definitions for the single-clock LCD FIFO: depth/pointer-width
// helpers and the read-mode selector constants.
package lcd_fifo_pkg;

  // Read-mode selector values for the FWFT parameter.
  localparam int unsigned FIFO_MODE_STD  = 32'd0;
  localparam int unsigned FIFO_MODE_FWFT = 32'd1;

  // Pointers carry one extra wrap bit above the RAM address.
  localparam int unsigned PTR_WRAP_BITS = 32'd1;

  // Number of RAM words for a given address width.
  function automatic int unsigned fifo_depth(input int unsigned depth_width);
    return 32'd1 << depth_width;
  endfunction

  // Pointer width (address plus wrap bit) for a given address width.
  function automatic int unsigned ptr_width(input int unsigned depth_width);
    return depth_width + PTR_WRAP_BITS;
  endfunction

endpackage

// File: rtl/lcd_sync_fifo_ram.sv
// Simple dual-port RAM for the FIFO storage.
// Ports: clk; rst_n (sync, active-low, clears only the read register);
//        we/waddr/wdata write port; re/raddr read enable/address;
//        rdata registered read word (holds when re is low).
module lcd_sync_fifo_ram #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [0:(2**ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Write port; the array itself is never reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Registered read port; this register doubles as the FIFO output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= {DATA_WIDTH{1'b0}};
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/lcd_sync_fifo.sv
// Single-clock synchronous FIFO with standard or first-word-fall-through read,
// synchronous flush, sticky overflow/underflow flags and one level count.
// Ports: clk; rst_n (sync, active-low); flush (sync clear of contents/flags);
//        wr_en/wr_data write side, wr_full RAM-full, almost_full level>=AF;
//        rd_en read/pop, rd_data read word, rd_empty, almost_empty level<=AE;
//        level words held; overflow/underflow sticky error flags.
module lcd_sync_fifo
  import lcd_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 16,
  parameter int unsigned DEPTH_WIDTH      = 9,
  parameter int unsigned FWFT             = FIFO_MODE_STD,
  parameter int unsigned ALMOST_FULL_NUM  = 508,
  parameter int unsigned ALMOST_EMPTY_NUM = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   wr_full,
  output logic                   almost_full,
  input  logic                   rd_en,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   rd_empty,
  output logic                   almost_empty,
  output logic [DEPTH_WIDTH:0]   level,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int unsigned      PTR_W   = ptr_width(DEPTH_WIDTH);
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(fifo_depth(DEPTH_WIDTH));
  localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ZRO = {PTR_W{1'b0}};

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic             out_valid_q, out_valid_d;
  logic [PTR_W-1:0] level_q, level_d;
  logic             wr_full_q, wr_full_d;
  logic             rd_empty_q, rd_empty_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic [PTR_W-1:0] mem_cnt_s;
  logic [PTR_W-1:0] mem_cnt_next_s;
  logic             wr_acc_s;
  logic             rd_acc_s;
  logic             ram_re_s;

  // Next-state logic for pointers, output-valid, flags and status outputs.
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    out_valid_d = out_valid_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    ram_re_s    = 1'b0;

    mem_cnt_s = wptr_q - rptr_q;
    // Acceptance uses the pre-edge full/empty state only.
    wr_acc_s  = wr_en & ~wr_full_q & ~flush;
    rd_acc_s  = rd_en & ~rd_empty_q & ~flush;

    if (flush) begin
      // Flush drops any concurrent access without flagging it.
      wptr_d      = PTR_ZRO;
      rptr_d      = PTR_ZRO;
      out_valid_d = 1'b0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      overflow_d  = overflow_q | (wr_en & wr_full_q);
      underflow_d = underflow_q | (rd_en & rd_empty_q);

      if (wr_acc_s) begin
        wptr_d = wptr_q + PTR_ONE;
      end else begin
        wptr_d = wptr_q;
      end

      if (FWFT == FIFO_MODE_FWFT) begin
        // Refill the output register when it is empty or being popped.
        ram_re_s = (~out_valid_q | rd_acc_s) & (mem_cnt_s != PTR_ZRO);
        if (ram_re_s) begin
          rptr_d      = rptr_q + PTR_ONE;
          out_valid_d = 1'b1;
        end else if (rd_acc_s) begin
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = out_valid_q;
        end
      end else begin
        ram_re_s = rd_acc_s;
        if (rd_acc_s) begin
          rptr_d = rptr_q + PTR_ONE;
        end else begin
          rptr_d = rptr_q;
        end
      end
    end

    // Status outputs are registered from the next-state pointers.
    mem_cnt_next_s = wptr_d - rptr_d;
    wr_full_d      = (mem_cnt_next_s == DEPTH_P);
    if (FWFT == FIFO_MODE_FWFT) begin
      rd_empty_d = ~out_valid_d;
      level_d    = mem_cnt_next_s + {{(PTR_W-1){1'b0}}, out_valid_d};
    end else begin
      rd_empty_d = (mem_cnt_next_s == PTR_ZRO);
      level_d    = mem_cnt_next_s;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q      <= PTR_ZRO;
      rptr_q      <= PTR_ZRO;
      out_valid_q <= 1'b0;
      level_q     <= PTR_ZRO;
      wr_full_q   <= 1'b0;
      rd_empty_q  <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      out_valid_q <= out_valid_d;
      level_q     <= level_d;
      wr_full_q   <= wr_full_d;
      rd_empty_q  <= rd_empty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // The RAM read register is the output register in both read modes.
  lcd_sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (DEPTH_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc_s),
    .waddr (wptr_q[DEPTH_WIDTH-1:0]),
    .wdata (wr_data),
    .re    (ram_re_s),
    .raddr (rptr_q[DEPTH_WIDTH-1:0]),
    .rdata (rd_data)
  );

  assign wr_full      = wr_full_q;
  assign rd_empty     = rd_empty_q;
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  // Thresholds compared at 32 bits so out-of-range values do not truncate.
  assign almost_full  = (32'(level_q) >= 32'(ALMOST_FULL_NUM));
  assign almost_empty = (32'(level_q) <= 32'(ALMOST_EMPTY_NUM));

endmodule
